// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device transmitter.
// Sends one command byte to the keyboard over the shared open-drain clock/data pair.
// The frame is an inhibit pulse, request-to-send, 8 data bits LSB first, odd parity,
// a stop bit, and a device ACK.
// Optional build macro PS2_TX_TIMEOUT_EN enables a watchdog. It abandons a transfer
// when the device stops clocking and reports the abort through err.
module ps2_host_transmitter #(
  parameter int INHIBIT_CYCLES = 5000
`ifdef PS2_TX_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 750000
`endif
) (
  input  logic       system_clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       send,
  input  logic       PS2_clk,
  input  logic       PS2_data,
  output logic       PS2_clk_drive_low,
  output logic       PS2_data_drive_low,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int INH_W = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 1;
`ifdef PS2_TX_TIMEOUT_EN
  localparam int WD_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_RELEASE_CLK,
    S_DATA,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic             clk_meta_q, clk_sync_q, clk_prev_q;
  logic             data_meta_q, data_sync_q;
  logic [9:0]       frame_q, frame_d;       // {stop, parity, data[7:0]}, shifted out LSB first
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [INH_W-1:0] inh_q, inh_d;
  logic             data_low_q, data_low_d; // data pull-down while the device clocks bits
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             fall_edge;
`ifdef PS2_TX_TIMEOUT_EN
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             wd_active;
`endif

  // Two-flop synchronizers for both PS/2 lines; the flops reset to the idle-high line level
  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= PS2_clk;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= PS2_data;
      data_sync_q <= data_meta_q;
    end
  end

  assign fall_edge = clk_prev_q & ~clk_sync_q;

  // State and datapath registers
  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      frame_q    <= '0;
      bit_cnt_q  <= '0;
      inh_q      <= '0;
      data_low_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      bit_cnt_q  <= bit_cnt_d;
      inh_q      <= inh_d;
      data_low_q <= data_low_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q       <= wd_d;
`endif
    end
  end

  // Next-state and datapath update; bits advance only on device clock falling edges
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    bit_cnt_d  = bit_cnt_q;
    inh_d      = inh_q;
    data_low_d = data_low_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
    wd_d       = wd_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        inh_d      = '0;
        bit_cnt_d  = '0;
        data_low_d = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
        wd_d       = '0;
`endif
        if (send) begin
          frame_d = {1'b1, ~^data_in, data_in};
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (inh_q == INH_W'(INHIBIT_CYCLES - 1)) begin
          inh_d   = '0;
          state_d = S_RTS;
        end else begin
          inh_d = inh_q + 1'b1;
        end
      end
      S_RTS: begin
        // The start bit stays on the line until the device's first falling edge
        data_low_d = 1'b1;
        bit_cnt_d  = '0;
        state_d    = S_RELEASE_CLK;
`ifdef PS2_TX_TIMEOUT_EN
        // The watchdog counts cycles since the RTS cycle
        wd_d       = WD_W'(1);
`endif
      end
      S_RELEASE_CLK: begin
        if (fall_edge) begin
          data_low_d = ~frame_q[0];
          frame_d    = {1'b1, frame_q[9:1]};
          bit_cnt_d  = 4'd1;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        // Edges n=1..7 send data, n=8 sends parity, n=9 sends the stop bit (line released)
        if (fall_edge) begin
          data_low_d = ~frame_q[0];
          frame_d    = {1'b1, frame_q[9:1]};
          bit_cnt_d  = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) begin
            state_d = S_ACK;
          end
        end
      end
      S_ACK: begin
        if (fall_edge) begin
          if (!data_sync_q) begin
            state_d = S_WAIT_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (clk_sync_q && data_sync_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
`ifdef PS2_TX_TIMEOUT_EN
    if (wd_active) begin
      wd_d = wd_q + 1'b1;
      if ((wd_q == WD_W'(TIMEOUT_CYCLES - 1)) && !done_d && !err_d) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
    end
`endif
  end

`ifdef PS2_TX_TIMEOUT_EN
  assign wd_active = (state_q == S_RELEASE_CLK) || (state_q == S_DATA) ||
                     (state_q == S_ACK)         || (state_q == S_WAIT_IDLE);
`endif

  // Line drivers and status decoded from registered state, so reset releases the lines at once
  always_comb begin
    PS2_clk_drive_low  = (state_q == S_INHIBIT) || (state_q == S_RTS);
    PS2_data_drive_low = (state_q == S_RTS) ||
                         (((state_q == S_RELEASE_CLK) || (state_q == S_DATA)) && data_low_q);
    busy               = (state_q != S_IDLE);
    done               = done_q;
    err                = err_q;
  end

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Directed testbench for ps2_host_transmitter with a behavioural keyboard model.
module tb_ps2_host_transmitter;

  localparam int INH  = 40;
  localparam int HALF = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       send = 1'b0;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       PS2_clk, PS2_data;
  logic       PS2_clk_drive_low, PS2_data_drive_low;
  logic       busy, done, err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  bit both_seen = 1'b0;
  bit busy_overlap = 1'b0;

  // Wired-AND open-drain lines with pull-ups
  assign PS2_clk  = ~(PS2_clk_drive_low | dev_clk_low);
  assign PS2_data = ~(PS2_data_drive_low | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_transmitter #(
    .INHIBIT_CYCLES(INH)
`ifdef PS2_TX_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(1000)
`endif
  ) dut (
    .system_clk        (clk),
    .reset             (reset),
    .data_in           (data_in),
    .send              (send),
    .PS2_clk           (PS2_clk),
    .PS2_data          (PS2_data),
    .PS2_clk_drive_low (PS2_clk_drive_low),
    .PS2_data_drive_low(PS2_data_drive_low),
    .busy              (busy),
    .done              (done),
    .err               (err)
  );

  // Pulse monitor sampled on the inactive edge
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (done && err) both_seen = 1'b1;
    if ((done || err) && busy) busy_overlap = 1'b1;
  end

  // Requests a byte, checks inhibit/RTS framing, then plays the keyboard for n_edges clocks
  task automatic drive_request(input logic [7:0] b, input bit ack, input int glitch_at,
                               input int abort_at, input int n_edges, output logic [9:0] bits);
    int inh;
    bits = '0;
    @(negedge clk);
    data_in = b;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    data_in = 8'h00;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_accept: got %b, expected 1", busy);
    end
    inh = 0;
    while (PS2_clk_drive_low === 1'b1 && PS2_data_drive_low === 1'b0 && inh < 4 * INH) begin
      inh++;
      @(negedge clk);
    end
    checks++;
    if (inh !== INH) begin
      errors++;
      $display("FAIL inhibit_len: got %0d cycles, expected %0d", inh, INH);
    end
    checks++;
    if ({PS2_clk_drive_low, PS2_data_drive_low} !== 2'b11) begin
      errors++;
      $display("FAIL rts_drive: got %b, expected 11", {PS2_clk_drive_low, PS2_data_drive_low});
    end
    @(negedge clk);
    checks++;
    if ({PS2_clk_drive_low, PS2_data_drive_low} !== 2'b01) begin
      errors++;
      $display("FAIL start_hold: got %b, expected 01", {PS2_clk_drive_low, PS2_data_drive_low});
    end
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < 10 && k < n_edges; k++) begin
      dev_clk_low = 1'b1;
      if (k == glitch_at) begin
        data_in = 8'hFF;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        data_in = 8'h00;
        repeat (HALF - 1) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      if (k == abort_at) return;
      bits[k] = PS2_data;
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    if (n_edges > 10) begin
      if (ack) dev_data_low = 1'b1;
      repeat (5) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_data_low = 1'b0;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({PS2_clk_drive_low, PS2_data_drive_low, busy, done, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, expected 00000",
               {PS2_clk_drive_low, PS2_data_drive_low, busy, done, err});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({PS2_clk_drive_low, PS2_data_drive_low, busy, done, err} !== 5'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got %b, expected 00000",
               {PS2_clk_drive_low, PS2_data_drive_low, busy, done, err});
    end
  endtask

  task automatic test_send_ed;
    logic [9:0] bits;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    drive_request(8'hED, 1'b1, -1, -1, 11, bits);
    for (int i = 0; i < 100 && done_cnt == d0 && err_cnt == e0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    $display("xfer 0xED: wire frame %h", bits);
    checks++;
    if (bits !== 10'h3ED) begin
      errors++;
      $display("FAIL ed_frame: got %h, expected 3ed", bits);
    end
    checks++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
      errors++;
      $display("FAIL ed_pulses: got done %0d err %0d, expected done 1 err 0", done_cnt - d0, err_cnt - e0);
    end
    checks++;
    if ({busy, PS2_clk_drive_low, PS2_data_drive_low} !== 3'b000) begin
      errors++;
      $display("FAIL ed_idle_after: got %b, expected 000", {busy, PS2_clk_drive_low, PS2_data_drive_low});
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] bits0, bits1;
    int d0;
    d0 = done_cnt;
    drive_request(8'h00, 1'b1, -1, -1, 11, bits0);
    for (int i = 0; i < 100 && done_cnt == d0; i++) @(negedge clk);
    drive_request(8'h01, 1'b1, -1, -1, 11, bits1);
    for (int i = 0; i < 100 && done_cnt == d0 + 1; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    $display("xfer 0x00: wire frame %h", bits0);
    $display("xfer 0x01: wire frame %h", bits1);
    checks++;
    if (bits0 !== 10'h300) begin
      errors++;
      $display("FAIL b2b_frame0: got %h, expected 300", bits0);
    end
    checks++;
    if (bits1 !== 10'h201) begin
      errors++;
      $display("FAIL b2b_frame1: got %h, expected 201", bits1);
    end
    checks++;
    if (done_cnt - d0 !== 2) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d, expected 2", done_cnt - d0);
    end
  endtask

  task automatic test_missing_ack;
    logic [9:0] bits;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    drive_request(8'h5A, 1'b0, -1, -1, 11, bits);
    for (int i = 0; i < 100 && err_cnt == e0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    $display("xfer 0x5A no-ack: wire frame %h", bits);
    checks++;
    if (bits !== 10'h35A) begin
      errors++;
      $display("FAIL nack_frame: got %h, expected 35a", bits);
    end
    checks++;
    if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin
      errors++;
      $display("FAIL nack_pulses: got err %0d done %0d, expected err 1 done 0", err_cnt - e0, done_cnt - d0);
    end
    checks++;
    if ({busy, PS2_clk_drive_low, PS2_data_drive_low} !== 3'b000) begin
      errors++;
      $display("FAIL nack_released: got %b, expected 000", {busy, PS2_clk_drive_low, PS2_data_drive_low});
    end
  endtask

  task automatic test_send_ignored;
    logic [9:0] bits;
    int d0;
    d0 = done_cnt;
    drive_request(8'h3C, 1'b1, 2, -1, 11, bits);
    for (int i = 0; i < 100 && done_cnt == d0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    $display("xfer 0x3C with mid-send 0xFF: wire frame %h", bits);
    checks++;
    if (bits !== 10'h33C) begin
      errors++;
      $display("FAIL ignore_frame: got %h, expected 33c", bits);
    end
    checks++;
    if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_single_done: got done %0d busy %b, expected done 1 busy 0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_reset_mid;
    logic [9:0] bits;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    drive_request(8'hED, 1'b1, -1, 4, 11, bits);
    checks++;
    if ({busy, PS2_data_drive_low} !== 2'b11) begin
      errors++;
      $display("FAIL mid_bit4_drive: got %b, expected 11", {busy, PS2_data_drive_low});
    end
    #1 reset = 1'b1;
    #1;
    $display("reset during bit 4: outputs %b", {PS2_clk_drive_low, PS2_data_drive_low, busy, done, err});
    checks++;
    if ({PS2_clk_drive_low, PS2_data_drive_low, busy, done, err} !== 5'b0) begin
      errors++;
      $display("FAIL mid_reset_release: got %b, expected 00000",
               {PS2_clk_drive_low, PS2_data_drive_low, busy, done, err});
    end
    dev_clk_low = 1'b0;
    dev_data_low = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt != d0 || err_cnt != e0) begin
      errors++;
      $display("FAIL mid_reset_no_pulse: got done %0d err %0d, expected 0 0", done_cnt - d0, err_cnt - e0);
    end
    drive_request(8'hF4, 1'b1, -1, -1, 11, bits);
    for (int i = 0; i < 100 && done_cnt == d0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    $display("xfer 0xF4 after reset: wire frame %h", bits);
    checks++;
    if (bits !== 10'h2F4 || done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL after_reset_xfer: got frame %h done %0d, expected 2f4 done 1", bits, done_cnt - d0);
    end
  endtask

`ifdef PS2_TX_TIMEOUT_EN
  task automatic test_timeout;
    logic [9:0] bits;
    int idx;
    drive_request(8'hFF, 1'b1, -1, -1, 0, bits);
    idx = HALF + 1;
    while (err !== 1'b1 && idx < 3000) begin
      @(negedge clk);
      idx++;
    end
    $display("silent device: err after %0d cycles from RTS", idx);
    checks++;
    if (idx !== 1000) begin
      errors++;
      $display("FAIL timeout_cycles: got %0d, expected 1000", idx);
    end
    checks++;
    if ({busy, PS2_clk_drive_low, PS2_data_drive_low, done} !== 4'b0000) begin
      errors++;
      $display("FAIL timeout_released: got %b, expected 0000",
               {busy, PS2_clk_drive_low, PS2_data_drive_low, done});
    end
    repeat (5) @(negedge clk);
  endtask
`else
  task automatic test_silent_device;
    logic [9:0] bits;
    int e0;
    e0 = err_cnt;
    drive_request(8'h12, 1'b1, -1, -1, 0, bits);
    repeat (1500) @(negedge clk);
    $display("silent device: busy %b err count %0d", busy, err_cnt - e0);
    checks++;
    if ({busy, PS2_clk_drive_low, PS2_data_drive_low} !== 3'b101 || err_cnt != e0) begin
      errors++;
      $display("FAIL silent_stays_busy: got %b err %0d, expected 101 err 0",
               {busy, PS2_clk_drive_low, PS2_data_drive_low}, err_cnt - e0);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL silent_reset_recover: got busy %b, expected 0", busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_send_ed();
    test_back_to_back();
    test_missing_ack();
    test_send_ignored();
    test_reset_mid();
`ifdef PS2_TX_TIMEOUT_EN
    test_timeout();
`else
    test_silent_device();
`endif
    checks++;
    if (both_seen || busy_overlap) begin
      errors++;
      $display("FAIL pulse_rules: got done&err %b busy-at-pulse %b, expected 0 0", both_seen, busy_overlap);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
